// File: rtl/ball_draw_ctrl.sv
// Ball sprite redraw sequencer: on a frame tick, erase the old square, then draw the new one, one pixel per clock.
// Optional macro BALL_CLIP_EN suppresses the plot strobe for pixels that fall outside SCREEN_W x SCREEN_H.
module ball_draw_ctrl #(
  parameter int         BALL_SIZE   = 2,
  parameter logic [2:0] BALL_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic       visible,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

  localparam logic [2:0] LAST = 3'(BALL_SIZE - 1);

  state_t     state_q, state_n;
  logic [2:0] dx_q, dy_q, dx_n, dy_n;
  logic [7:0] old_x, new_x, base_x;
  logic [6:0] old_y, new_y, base_y;
  logic       new_vis, have_prev;
  logic       emit, in_scr;

  // Next-state / next-pixel logic; the output registers below load the pixel
  // selected here so that the first pixel appears the cycle after the tick.
  always_comb begin
    state_n = state_q;
    dx_n    = dx_q;
    dy_n    = dy_q;
    case (state_q)
      IDLE: if (tick) begin
        dx_n = '0;
        dy_n = '0;
        if (have_prev)    state_n = ERASE;
        else if (visible) state_n = DRAW;
        else              state_n = FIN;
      end
      ERASE, DRAW: begin
        if (dx_q == LAST && dy_q == LAST) begin
          dx_n    = '0;
          dy_n    = '0;
          state_n = (state_q == ERASE && new_vis) ? DRAW : FIN;
        end else if (dx_q == LAST) begin
          dx_n = '0;
          dy_n = dy_q + 3'd1;
        end else begin
          dx_n = dx_q + 3'd1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A draw entered straight from IDLE must use the live inputs, not yet latched.
  always_comb begin
    emit   = (state_n == ERASE) || (state_n == DRAW);
    base_x = new_x;
    base_y = new_y;
    if (state_n == ERASE) begin
      base_x = old_x;
      base_y = old_y;
    end else if (state_q == IDLE) begin
      base_x = ball_x;
      base_y = ball_y;
    end
  end

`ifdef BALL_CLIP_EN
  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);
  logic [8:0] full_x;
  logic [7:0] full_y;
  always_comb begin
    full_x = {1'b0, base_x} + {6'd0, dx_n};
    full_y = {1'b0, base_y} + {5'd0, dy_n};
    in_scr = (full_x < SW) && (full_y < SH);
  end
`else
  assign in_scr = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dx_q       <= '0;
      dy_q       <= '0;
      old_x      <= '0;
      old_y      <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_vis    <= 1'b0;
      have_prev  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state_q <= state_n;
      dx_q    <= dx_n;
      dy_q    <= dy_n;
      if (state_q == IDLE && tick) begin
        new_x   <= ball_x;
        new_y   <= ball_y;
        new_vis <= visible;
      end
      if (state_q == FIN) begin
        old_x     <= new_x;
        old_y     <= new_y;
        have_prev <= new_vis;
      end
      vga_plot   <= emit && in_scr;
      vga_colour <= !emit ? 3'b000 : (state_n == ERASE) ? BG_COLOUR : BALL_COLOUR;
      if (emit) begin
        vga_x <= base_x + {5'd0, dx_n};
        vga_y <= base_y + {4'd0, dy_n};
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
endmodule

// File: tb/tb_ball_draw_ctrl.sv
// Directed bench for ball_draw_ctrl (BALL_SIZE=2); drives on the falling edge and samples there too.
module tb_ball_draw_ctrl;
  logic       clock = 1'b0;
  logic       reset, tick, visible;
  logic [7:0] ball_x, vga_x;
  logic [6:0] ball_y, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;
  int         vectors = 0;
  int         errors  = 0;

  ball_draw_ctrl dut (
    .clock(clock), .reset(reset), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .visible(visible), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the pixel on the outputs this cycle, optionally drive tick, advance one cycle.
  task automatic px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                    input logic p, input logic t);
    chk("pixel", 32'({vga_plot, vga_colour, vga_x, vga_y}), 32'({p, c, x, y}));
    chk("busy_px", 32'(busy), 32'd1);
    chk("done_px", 32'(done), 32'd0);
    tick = t;
    @(negedge clock);
  endtask

  task automatic fin();
    chk("done_pulse", 32'(done), 32'd1);
    chk("fin_plot", 32'({vga_plot, vga_colour}), 32'd0);
    chk("busy_fin", 32'(busy), 32'd1);
    @(negedge clock);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic start(input logic [7:0] x, input logic [6:0] y, input logic v);
    tick = 1'b1; ball_x = x; ball_y = y; visible = v;
    @(negedge clock);
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; visible = 1'b0; ball_x = '0; ball_y = '0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_out", 32'({vga_plot, vga_colour, vga_x, vga_y, busy, done}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: first frame, draw only
    start(8'd20, 7'd20, 1'b1);
    px(20, 20, 3'b111, 1, 0); px(21, 20, 3'b111, 1, 0);
    px(20, 21, 3'b111, 1, 0); px(21, 21, 3'b111, 1, 0);
    fin();

    // 2: erase previous then draw
    start(8'd21, 7'd21, 1'b1);
    px(20, 20, 3'b000, 1, 0); px(21, 20, 3'b000, 1, 0);
    px(20, 21, 3'b000, 1, 0); px(21, 21, 3'b000, 1, 0);
    px(21, 21, 3'b111, 1, 0); px(22, 21, 3'b111, 1, 0);
    px(21, 22, 3'b111, 1, 0); px(22, 22, 3'b111, 1, 0);
    fin();

    // 3: same position, ticks in cycles 2 and 4 and moving inputs are ignored
    start(8'd21, 7'd21, 1'b1);
    ball_x = 8'd99; ball_y = 7'd99;
    px(21, 21, 3'b000, 1, 0); px(22, 21, 3'b000, 1, 1);
    px(21, 22, 3'b000, 1, 0); px(22, 22, 3'b000, 1, 1);
    px(21, 21, 3'b111, 1, 0); px(22, 21, 3'b111, 1, 0);
    px(21, 22, 3'b111, 1, 0); px(22, 22, 3'b111, 1, 0);
    fin();
    @(negedge clock);
    chk("no_second_done", 32'({done, busy}), 32'd0);

    // 4: invisible frame erases only; the next visible frame has nothing to erase
    start(8'd21, 7'd21, 1'b0);
    px(21, 21, 3'b000, 1, 0); px(22, 21, 3'b000, 1, 0);
    px(21, 22, 3'b000, 1, 0); px(22, 22, 3'b000, 1, 0);
    fin();
    start(8'd40, 7'd10, 1'b1);
    px(40, 10, 3'b111, 1, 0); px(41, 10, 3'b111, 1, 0);
    px(40, 11, 3'b111, 1, 0); px(41, 11, 3'b111, 1, 0);
    fin();

    // 5: reset in cycle 2 of a draw clears outputs immediately
    start(8'd60, 7'd30, 1'b0);
    px(40, 10, 3'b000, 1, 0); px(41, 10, 3'b000, 1, 0);
    px(40, 11, 3'b000, 1, 0); px(41, 11, 3'b000, 1, 0);
    fin();
    start(8'd60, 7'd30, 1'b1);
    px(60, 30, 3'b111, 1, 0);
    chk("pixel_c2", 32'({vga_plot, vga_colour, vga_x, vga_y}), 32'({1'b1, 3'b111, 8'd61, 7'd30}));
    reset = 1'b1;
    #1;
    chk("mid_reset", 32'({vga_plot, vga_colour, vga_x, vga_y, busy, done}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start(8'd5, 7'd5, 1'b1);
    px(5, 5, 3'b111, 1, 0); px(6, 5, 3'b111, 1, 0);
    px(5, 6, 3'b111, 1, 0); px(6, 6, 3'b111, 1, 0);
    fin();

    // 6: bottom-right corner
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start(8'd159, 7'd119, 1'b1);
`ifdef BALL_CLIP_EN
    px(159, 119, 3'b111, 1, 0); px(160, 119, 3'b111, 0, 0);
    px(159, 120, 3'b111, 0, 0); px(160, 120, 3'b111, 0, 0);
`else
    px(159, 119, 3'b111, 1, 0); px(160, 119, 3'b111, 1, 0);
    px(159, 120, 3'b111, 1, 0); px(160, 120, 3'b111, 1, 0);
`endif
    fin();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
